// File: rtl/key_cond_pkg.sv
// key_cond_pkg: shared FSM state type and sizing defaults for key_conditioner
package key_cond_pkg;
  typedef enum logic [1:0] {IDLE, FIRE, HOLD} state_t;
  localparam int NUM_KEY = 4;
  localparam int DEBOUNCE_DEFAULT = 4;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchronizer followed by a counter debouncer for one channel
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic deb
);
  localparam logic [2:0] LIMIT = 3'(DEBOUNCE_CYCLES - 1);
  logic s1, s2;
  logic [2:0] cnt;
  always_ff @(posedge clock)
    if (reset) begin
      {s1, s2, deb, cnt} <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      cnt <= (s2 == deb || cnt == LIMIT) ? 3'd0 : cnt + 3'd1;
      if (s2 != deb && cnt == LIMIT) deb <= s2;
    end
endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: debounces keys and start, emits one-cycle key/start press pulses
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int NUM_KEY = key_cond_pkg::NUM_KEY
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_KEY-1:0] raw_key,
  input  logic               raw_start,
  output logic [NUM_KEY-1:0] k,
  output logic               start,
  output logic               busy
);
  logic [NUM_KEY:0] raw_all, deb, deb_d, rise;
  logic [NUM_KEY-1:0] key_rise, low;
  state_t state, next;
  assign raw_all = {raw_start, raw_key};
  assign rise = deb & ~deb_d;
  assign key_rise = rise[NUM_KEY-1:0];
  // isolate the lowest-index rising key
  assign low = key_rise & (-key_rise);
  for (genvar i = 0; i <= NUM_KEY; i++) begin : g_ch
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clock(clock),
      .reset(reset),
      .raw(raw_all[i]),
      .deb(deb[i])
    );
  end
  always_comb
    next = state == IDLE ? (|key_rise ? FIRE : IDLE)
         : state == FIRE ? HOLD
         : (|deb[NUM_KEY-1:0] ? HOLD : IDLE);
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      deb_d <= '0;
      k <= '0;
      start <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= next;
      deb_d <= deb;
      k <= state == IDLE ? low : '0;
      start <= rise[NUM_KEY];
      busy <= next != IDLE;
    end
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: table vectors, corner sequences and random bounce vs. a history-window model
module tb_key_conditioner;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [3:0] raw_key = '0;
  logic raw_start = 1'b0;
  logic [3:0] k, k1;
  logic start, start1, busy, busy1;
  int n_chk = 0, n_fail = 0;
  int nk, ns, fk, fs;
  logic [3:0] kv;

  key_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .raw_key(raw_key), .raw_start(raw_start),
    .k(k), .start(start), .busy(busy));
  key_conditioner #(.DEBOUNCE_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset), .raw_key(raw_key), .raw_start(raw_start),
    .k(k1), .start(start1), .busy(busy1));

  always #5 clock = ~clock;

  // model: a channel's level flips once its last N synchronized samples all disagree with it
  logic [4:0] hq [2][$];
  logic [4:0] mdeb [2], mprev [2];
  bit eng [2], fresh [2];
  logic [3:0] ek [2];
  logic es [2], eb [2];

  task automatic model_step(int m);
    int n = m ? 1 : 4;
    int len, idx;
    logic [4:0] nd, rise;
    logic [3:0] oh;
    bit all;
    logic s;
    if (reset) begin
      hq[m].delete();
      mdeb[m] = '0; mprev[m] = '0; eng[m] = 0; fresh[m] = 0;
      ek[m] = '0; es[m] = 1'b0; eb[m] = 1'b0;
      return;
    end
    rise = mdeb[m] & ~mprev[m];
    es[m] = rise[4];
    ek[m] = '0;
    if (!eng[m]) begin
      if (|rise[3:0]) begin
        oh = '0;
        for (int i = 3; i >= 0; i--) if (rise[i]) oh = 4'b0001 << i;
        ek[m] = oh; eng[m] = 1; fresh[m] = 1;
      end
    end else if (fresh[m]) fresh[m] = 0;
    else if (mdeb[m][3:0] == 4'b0000) eng[m] = 0;
    eb[m] = eng[m];
    len = hq[m].size();
    nd = mdeb[m];
    for (int c = 0; c < 5; c++) begin
      all = 1;
      for (int j = 0; j < n; j++) begin
        idx = len - 2 - j;
        s = (idx >= 0) ? hq[m][idx][c] : 1'b0;
        if (s == mdeb[m][c]) all = 0;
      end
      if (all) nd[c] = ~mdeb[m][c];
    end
    mprev[m] = mdeb[m];
    mdeb[m] = nd;
    hq[m].push_back({raw_start, raw_key});
    if (hq[m].size() > 12) void'(hq[m].pop_front());
  endtask

  task automatic chk(string nm, logic [3:0] act, logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_i(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step(0);
    model_step(1);
    #1;
    chk("model_k", k, ek[0]);
    chk("model_start", {3'b0, start}, {3'b0, es[0]});
    chk("model_busy", {3'b0, busy}, {3'b0, eb[0]});
    chk("model_k_n1", k1, ek[1]);
    chk("model_start_n1", {3'b0, start1}, {3'b0, es[1]});
    chk("model_busy_n1", {3'b0, busy1}, {3'b0, eb[1]});
  endtask

  task automatic do_reset();
    raw_key = '0; raw_start = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic run(int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (k != 0) begin nk++; kv = k; if (fk < 0) fk = i; end
      if (start) begin ns++; if (fs < 0) fs = i; end
    end
  endtask

  task automatic clr();
    nk = 0; ns = 0; fk = -1; fs = -1; kv = '0;
  endtask

  typedef struct {
    logic [3:0] rk;
    logic rs;
    logic [3:0] xk;
    logic xs;
  } vec_t;
  vec_t tbl [7];

  initial begin
    tbl[0] = '{4'b0001, 1'b0, 4'b0001, 1'b0};
    tbl[1] = '{4'b1010, 1'b0, 4'b0010, 1'b0};
    tbl[2] = '{4'b1000, 1'b1, 4'b1000, 1'b1};
    tbl[3] = '{4'b0110, 1'b0, 4'b0010, 1'b0};
    tbl[4] = '{4'b0000, 1'b1, 4'b0000, 1'b1};
    tbl[5] = '{4'b1111, 1'b0, 4'b0001, 1'b0};
    tbl[6] = '{4'b0000, 1'b0, 4'b0000, 1'b0};

    do_reset();
    chk("reset_k", k, 4'b0000);
    chk("reset_start", {3'b0, start}, 4'b0000);
    chk("reset_busy", {3'b0, busy}, 4'b0000);

    foreach (tbl[v]) begin
      do_reset();
      raw_key = tbl[v].rk; raw_start = tbl[v].rs;
      clr();
      run(30);
      chk("tbl_kval", kv, tbl[v].xk);
      chk_i("tbl_kcnt", nk, tbl[v].xk != 0 ? 1 : 0);
      chk_i("tbl_kcyc", fk, tbl[v].xk != 0 ? 6 : -1);
      chk_i("tbl_scnt", ns, tbl[v].xs ? 1 : 0);
      chk_i("tbl_scyc", fs, tbl[v].xs ? 6 : -1);
      chk("tbl_busy", {3'b0, busy}, {3'b0, tbl[v].xk != 0});
    end

    // single key press then release: busy drops N+2 cycles after release
    do_reset();
    raw_key = 4'b0001;
    run(20);
    raw_key = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("release_busy", {3'b0, busy}, {3'b0, i < 6});
    end

    // short bounce on key 2
    do_reset();
    clr();
    raw_key = 4'b0100;
    run(3);
    raw_key = 4'b0000;
    run(20);
    chk_i("bounce_kcnt", nk, 0);
    chk("bounce_busy", {3'b0, busy}, 4'b0000);

    // simultaneous 1010, release key1 while key3 held
    do_reset();
    clr();
    raw_key = 4'b1010;
    run(10);
    raw_key = 4'b1000;
    run(20);
    chk_i("simul_kcnt", nk, 1);
    chk("simul_kval", kv, 4'b0010);
    chk("simul_busy_held", {3'b0, busy}, 4'b0001);
    raw_key = 4'b0000;
    run(10);
    chk_i("simul_kcnt_after", nk, 1);
    chk("simul_busy_rel", {3'b0, busy}, 4'b0000);

    // key3 and start together
    do_reset();
    raw_key = 4'b1000; raw_start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("same_k", k, i == 6 ? 4'b1000 : 4'b0000);
      chk("same_start", {3'b0, start}, {3'b0, i == 6});
    end

    // reset while held in HOLD
    do_reset();
    raw_key = 4'b0001;
    run(15);
    reset = 1'b1;
    tick();
    chk("midrst_busy", {3'b0, busy}, 4'b0000);
    chk("midrst_k", k, 4'b0000);
    reset = 1'b0;
    for (int j = 0; j < 12; j++) begin
      tick();
      chk("postrst_k", k, j == 6 ? 4'b0001 : 4'b0000);
    end

    // N=1 instance: held key fires once, three cycles after first sample
    do_reset();
    raw_key = 4'b0010;
    nk = 0; fk = -1; kv = '0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (k1 != 0) begin nk++; kv = k1; if (fk < 0) fk = i; end
    end
    chk_i("n1_kcyc", fk, 3);
    chk_i("n1_kcnt", nk, 1);
    chk("n1_kval", kv, 4'b0010);

    // random bouncing with bursty and calm phases, occasional reset
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      int rate;
      int b;
      logic [4:0] w;
      rate = ((c / 300) % 2 == 1) ? 2 : 14;
      w = {raw_start, raw_key};
      if ($urandom_range(rate - 1) == 0) begin
        b = $urandom_range(4);
        w[b] = ~w[b];
      end
      {raw_start, raw_key} = w;
      reset = ($urandom_range(399) == 0);
      tick();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, number of consecutive stable synchronized samples needed to accept a level change; legal range 1..7.
REQ-002 Parameter NUM_KEY, default 4, number of key channels; fixed at 4 in this revision.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 raw_key  input  4  asynchronous, bouncing push-button levels; 1 = pressed.
REQ-006 raw_start  input  1  asynchronous, bouncing start button level; 1 = pressed.
REQ-007 k  output  4  registered one-hot key-press pulse, one cycle wide; feeds the game controller key input.
REQ-008 start  output  1  registered start pulse, one cycle wide; feeds the game controller start input.
REQ-009 busy  output  1  registered; high while a key press is latched and not yet fully released.

Function
REQ-010 Each of the 5 channels (raw_key[3:0], raw_start) SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 Each channel SHALL hold a debounced level (deb) and a 3-bit counter: counter clears when sync == deb; otherwise counter increments; when counter reaches DEBOUNCE_CYCLES-1 while sync != deb, deb <= sync and counter clears.
REQ-012 A bounce shorter than DEBOUNCE_CYCLES consecutive samples SHALL leave deb unchanged and produce no output.
REQ-013 start SHALL be 1 for exactly one cycle, in the cycle after deb_start rises 0->1; a falling deb_start produces nothing.
REQ-014 start generation SHALL be independent of the key FSM and of busy.
REQ-015 Key FSM states: IDLE, FIRE, HOLD.
REQ-016 IDLE: if any deb_key rises 0->1 this cycle, latch the one-hot of the lowest-index rising key, go to FIRE; else stay.
REQ-017 FIRE: k = latched one-hot for this single cycle; go to HOLD unconditionally.
REQ-018 HOLD: k = 0; stay until all four deb_key are 0, then go to IDLE.
REQ-019 k SHALL be 0 in IDLE and HOLD; never more than one bit high.
REQ-020 busy SHALL be 1 in FIRE and HOLD, 0 in IDLE.
REQ-021 Simultaneous rises: lowest index wins; other keys produce no pulse until all keys are released and pressed again.
REQ-022 Any key pressed while in FIRE/HOLD SHALL be ignored, even after the first key is released, until all keys are low.
REQ-023 Latency (key or start): raw high, sampled at edge t and held -> output pulse high during the cycle following edge t+DEBOUNCE_CYCLES+2.
REQ-024 Key press and start press completing debounce in the same cycle SHALL both be emitted in the same cycle.

Reset
REQ-025 While reset is high at a clock edge: synchronizers, deb levels, counters = 0; FSM = IDLE; k = 0, start = 0, busy = 0.
REQ-026 Reset mid-HOLD or mid-debounce SHALL discard all history; a button still held after reset deasserts SHALL be treated as a new press and emit one pulse after full debounce latency.
REQ-027 No output pulse SHALL be emitted in the cycle reset is high or the first cycle after it.

Structure
REQ-028 Package key_cond_pkg SHALL hold the FSM state type (IDLE, FIRE, HOLD), NUM_KEY and the DEBOUNCE_CYCLES default.
REQ-029 Sub-module key_debounce (synchronizer + counter + deb register, one channel, parameterized by DEBOUNCE_CYCLES) SHALL be instantiated 5 times; FSM and pulse logic live in key_conditioner.

Verification
REQ-030 raw_key=4'b0001 held from edge 0, N=4 -> k=4'b0001 for exactly one cycle after edge 6, busy=1 from then until 2+N cycles after release.
REQ-031 raw_key[2] toggling high for 3 cycles then low, N=4 -> k stays 0, busy stays 0.
REQ-032 raw_key=4'b1010 rising same edge -> single pulse k=4'b0010; releasing key1 while key3 held -> no pulse for key3.
REQ-033 raw_start and raw_key[3] rising same edge -> start=1 and k=4'b1000 in the same cycle, one cycle each.
REQ-034 reset pulsed for 1 cycle while raw_key[0] held in HOLD -> busy=0 immediately, then k=4'b0001 once, N+3 cycles after reset deasserts.
REQ-035 N=1 build, raw_key[1] held -> k=4'b0010 three cycles after first sample; one pulse only over 100 cycles held.
